// File: rtl/rmt_alu_pkg.sv
// Shared types and constants for the match-action ALU request arbiter.
// State encodings, opcode field position and opcode values.
package rmt_alu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_t;

  localparam int ALU_OP_MSB = 24;
  localparam int ALU_OP_LSB = 21;

  localparam logic [3:0] ALU_OP_ADD = 4'b0001;
  localparam logic [3:0] ALU_OP_SUB = 4'b0010;
  localparam logic [3:0] ALU_OP_OR  = 4'b0101;
  localparam logic [3:0] ALU_OP_GEQ = 4'b0110;
  localparam logic [3:0] ALU_OP_SET = 4'b1110;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request after last_grant, wrapping.
// Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx
);

  logic            found;
  logic [IDXW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDXW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NUM_REQ requesters: grant, issue, wait, respond.
// Optional WAIT watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_req_arbiter
  import rmt_alu_pkg::*;
#(
  parameter int STAGE_ID       = 0,
  parameter int ACTION_LEN     = 25,
  parameter int DATA_WIDTH     = 48,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ACTION_LEN-1:0] req_action,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic [ACTION_LEN-1:0]         alu_action,
  output logic                          alu_action_valid,
  output logic [DATA_WIDTH-1:0]         alu_operand_1,
  output logic [DATA_WIDTH-1:0]         alu_operand_2,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_result_valid,
  output logic [31:0]                   op_count
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
      STAGE_ID < 0) begin : g_bad_param
    $error("alu_req_arbiter: parameter out of range");
  end

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [IDXW-1:0]    last_grant_q;
  logic [IDXW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] grant_q;
  logic               accept;
  logic               result_take;
  logic               timeout;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready        = accept ? grant : '0;
  assign alu_action_valid = (state_q == ISSUE);

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    result_take = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && |req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A response in the limit cycle beats the watchdog.
        if (alu_result_valid) begin
          result_take = 1'b1;
          state_d     = RESP;
        end else if (timeout_hit) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= IDXW'(NUM_REQ - 1);
      grant_q       <= '0;
      alu_action    <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      op_count      <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        grant_q       <= grant;
        last_grant_q  <= grant_idx;
        alu_action    <= req_action[grant_idx*ACTION_LEN +: ACTION_LEN];
        alu_operand_1 <= req_op1[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        alu_operand_2 <= req_op2[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (result_take) begin
        resp_valid <= grant_q;
        resp_data  <= alu_result;
      end else if (timeout) begin
        resp_valid <= grant_q;
        resp_data  <= '0;
      end
      if (state_q == RESP) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_err <= timeout;
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  assign timeout_hit = (wait_cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a 2-cycle ALU stand-in.
// Define ALU_ARB_TIMEOUT_EN to also run the watchdog scenario.
module tb_alu_req_arbiter;
  import rmt_alu_pkg::*;

  localparam int NR = 4;
  localparam int AL = 25;
  localparam int DW = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AL-1:0] req_action;
  logic [NR*DW-1:0] req_op1;
  logic [NR*DW-1:0] req_op2;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic [AL-1:0]    alu_action;
  logic             alu_action_valid;
  logic [DW-1:0]    alu_operand_1;
  logic [DW-1:0]    alu_operand_2;
  logic [DW-1:0]    alu_result;
  logic             alu_result_valid;
  logic [31:0]      op_count;

  logic          withhold;
  logic          stray;
  logic          s1_v, s2_v;
  logic [DW-1:0] s1_r, s2_r;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .STAGE_ID(0), .ACTION_LEN(AL), .DATA_WIDTH(DW),
    .NUM_REQ(NR), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_action(req_action), .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .alu_action(alu_action), .alu_action_valid(alu_action_valid),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .op_count(op_count)
  );

  function automatic logic [DW-1:0] alu_calc(
    input logic [AL-1:0] act, input logic [DW-1:0] a, b);
    logic [3:0] op;
    op = act[ALU_OP_MSB:ALU_OP_LSB];
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_OR:  return a | b;
      ALU_OP_GEQ: return (a >= b) ? 48'd1 : 48'd0;
      ALU_OP_SET: return b;
      default:    return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= alu_action_valid;
      s1_r <= alu_calc(alu_action, alu_operand_1, alu_operand_2);
      s2_v <= s1_v;
      s2_r <= s1_r;
    end
  end

  assign alu_result_valid = (s2_v & ~withhold) | stray;
  assign alu_result       = s2_r;

  task automatic drive_req(input int i, input logic [3:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]          = 1'b1;
    req_action[i*AL +: AL] = {op, 21'h0};
    req_op1[i*DW +: DW]    = a;
    req_op2[i*DW +: DW]    = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    stray = 1'b0;
    withhold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    n_checks++;
    if (resp_valid !== 4'b0000 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got %b/%b expected 0000/0", resp_valid, resp_err);
    end
    n_checks++;
    if (op_count !== 32'd0 || alu_action_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%b expected 0/0", op_count, alu_action_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_add();
    exp_t e;
    int lat;
    logic [31:0] oc0;
    oc0 = op_count;
    drive_req(2, ALU_OP_ADD, 48'd5, 48'd7);
    sb.push_back('{2, 48'd12, 1'b0});
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL add_ready: got %b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++;
    if (alu_action_valid !== 1'b1 ||
        alu_action[ALU_OP_MSB:ALU_OP_LSB] !== ALU_OP_ADD) begin
      n_fail++;
      $display("FAIL add_issue: got %b/%h expected 1/%h", alu_action_valid,
               alu_action[ALU_OP_MSB:ALU_OP_LSB], ALU_OP_ADD);
    end
    n_checks++;
    if (alu_operand_1 !== 48'd5 || alu_operand_2 !== 48'd7) begin
      n_fail++;
      $display("FAIL add_ops: got %0d,%0d expected 5,7", alu_operand_1, alu_operand_2);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (alu_action_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_issue_once: got %b expected 0", alu_action_valid);
    end
    lat = 2;
    while (resp_valid === 4'b0000 && lat < 30) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (resp_valid === 4'b0000 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL add_resp_timeout: got none expected response");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== 4'(1 << e.idx) || resp_data !== e.data ||
          resp_err !== e.err || lat != 4) begin
        n_fail++;
        $display("FAIL add_resp: got %b/%0d/%b lat %0d expected %b/%0d/%b lat 4",
                 resp_valid, resp_data, resp_err, lat, 4'(1 << e.idx), e.data, e.err);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (op_count !== oc0 + 32'd1 || resp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_count: got %0d/%b expected %0d/0000", op_count, resp_valid, oc0 + 1);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int ngrant = 0;
    int nresp = 0;
    int last_resp = 0;
    int gi;
    do_reset();
    for (int i = 0; i < NR; i++) drive_req(i, ALU_OP_SUB, 48'd10, 48'd3);
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        gi = 0;
        for (int k = 0; k < NR; k++) if (req_ready[k]) gi = k;
        n_checks++;
        if (req_ready !== 4'(1 << (ngrant % NR))) begin
          n_fail++;
          $display("FAIL cont_grant%0d: got %b expected %b", ngrant, req_ready,
                   4'(1 << (ngrant % NR)));
        end
        sb.push_back('{gi, 48'd7, 1'b0});
        ngrant++;
      end
      if (resp_valid !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL cont_resp%0d: got %b expected none", nresp, resp_valid);
        end else begin
          e = sb.pop_front();
          if (resp_valid !== 4'(1 << e.idx) || resp_data !== e.data ||
              (nresp > 0 && c - last_resp != 5)) begin
            n_fail++;
            $display("FAIL cont_resp%0d: got %b/%0d gap %0d expected %b/%0d gap 5",
                     nresp, resp_valid, resp_data, c - last_resp, 4'(1 << e.idx), e.data);
          end
        end
        last_resp = c;
        nresp++;
        if (nresp == 5) begin
          req_valid = '0;
          break;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (nresp != 5 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL cont_total: got %0d resp %0d left expected 5 resp 0 left",
               nresp, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int ngrant = 0;
    int nresp = 0;
    int last_g = 0;
    int pend = 0;
    repeat (2) @(negedge clk);
    drive_req(1, ALU_OP_GEQ, 48'd3, 48'd9);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        n_checks++;
        if (req_ready !== 4'b0010 || (ngrant == 1 && c - last_g != 5)) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: got %b gap %0d expected 0010 gap 5",
                   ngrant, req_ready, c - last_g);
        end
        sb.push_back('{1, (ngrant == 0) ? 48'd0 : 48'd1, 1'b0});
        last_g = c;
        ngrant++;
        pend = ngrant;
      end
      if (resp_valid !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: got %b expected none", nresp, resp_valid);
        end else begin
          e = sb.pop_front();
          if (resp_valid !== 4'(1 << e.idx) || resp_data !== e.data) begin
            n_fail++;
            $display("FAIL b2b_resp%0d: got %b/%0d expected %b/%0d", nresp,
                     resp_valid, resp_data, 4'(1 << e.idx), e.data);
          end
        end
        nresp++;
        if (nresp == 2) break;
      end
      @(negedge clk);
      if (pend == 1) drive_req(1, ALU_OP_GEQ, 48'd9, 48'd3);
      if (pend == 2) req_valid = '0;
      pend = 0;
    end
    n_checks++;
    if (nresp != 2 || ngrant != 2) begin
      n_fail++;
      $display("FAIL b2b_total: got %0d grants %0d resp expected 2 2", ngrant, nresp);
    end
  endtask

  task automatic test_stray();
    logic [31:0] oc0;
    int seen = 0;
    repeat (3) @(negedge clk);
    oc0 = op_count;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (resp_valid !== 4'b0000 || alu_action_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL stray_resp: got %0d active cycles expected 0", seen);
    end
    n_checks++;
    if (op_count !== oc0) begin
      n_fail++;
      $display("FAIL stray_count: got %0d expected %0d", op_count, oc0);
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    int lat;
    int seen = 0;
    drive_req(0, ALU_OP_ADD, 48'd1, 48'd2);
    sb.push_back('{0, 48'd3, 1'b0});
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_wait_ready: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 4'b0000 || resp_data !== 48'd0 || resp_err !== 1'b0 ||
        req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_wait_resp: got %b/%0d/%b/%b expected 0", resp_valid,
               resp_data, resp_err, req_ready);
    end
    n_checks++;
    if (alu_action !== '0 || alu_action_valid !== 1'b0 ||
        alu_operand_1 !== '0 || alu_operand_2 !== '0 || op_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_wait_alu: got %h/%b/%0d/%0d/%0d expected 0", alu_action,
               alu_action_valid, alu_operand_1, alu_operand_2, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      #1;
      if (resp_valid !== 4'b0000) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_wait_drop: got %0d responses expected 0", seen);
    end
    drive_req(3, ALU_OP_OR, 48'hF0, 48'h0F);
    sb.push_back('{3, 48'hFF, 1'b0});
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_wait_regrant: got %b expected 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (resp_valid === 4'b0000 && lat < 30) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (resp_valid === 4'b0000 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rst_wait_or_timeout: got none expected response");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== 4'(1 << e.idx) || resp_data !== e.data || lat != 4) begin
        n_fail++;
        $display("FAIL rst_wait_or: got %b/%h lat %0d expected %b/%h lat 4",
                 resp_valid, resp_data, lat, 4'(1 << e.idx), e.data);
      end
    end
  endtask

`ifdef ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int lat;
    logic [31:0] oc0;
    repeat (2) @(negedge clk);
    oc0 = op_count;
    withhold = 1'b1;
    drive_req(2, ALU_OP_ADD, 48'd1, 48'd1);
    sb.push_back('{2, 48'd0, 1'b1});
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (resp_valid === 4'b0000 && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (resp_valid === 4'b0000 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL timeout_none: got none expected error response");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== 4'(1 << e.idx) || resp_data !== e.data ||
          resp_err !== e.err || lat != 17) begin
        n_fail++;
        $display("FAIL timeout_resp: got %b/%0d/%b lat %0d expected %b/%0d/%b lat 17",
                 resp_valid, resp_data, resp_err, lat, 4'(1 << e.idx), e.data, e.err);
      end
    end
    withhold = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (op_count !== oc0 + 32'd1 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d/%b expected %0d/0", op_count, resp_err, oc0 + 1);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_action = '0;
    req_op1    = '0;
    req_op2    = '0;
    withhold   = 1'b0;
    stray      = 1'b0;
    test_reset();
    test_single_add();
    test_contention();
    test_back_to_back();
    test_stray();
    test_reset_in_wait();
`ifdef ALU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer sharing one `alu_1` instance among `NUM_REQ` sub-action requesters within a match-action stage. It accepts one request at a time and drives the ALU's single-cycle `action_valid` issue. It waits out the ALU's fixed latency and returns the result to the granted requester. An optional watchdog handles a missing ALU response.

## Interface
- `STAGE_ID`, 0, stage index; informational only.
- `ACTION_LEN`, 25, action word width; opcode in bits [24:21].
- `DATA_WIDTH`, 48, operand/result width.
- `NUM_REQ`, 4, number of requesters (2..8).
- `TIMEOUT_CYCLES`, 15, watchdog limit in WAIT (used only with the watchdog macro).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept pulse, combinational.
- `req_action`  in  NUM_REQ*ACTION_LEN  flattened actions; requester i occupies slice i.
- `req_op1`, `req_op2`  in  NUM_REQ*DATA_WIDTH  flattened operands.
- `resp_valid`  out  NUM_REQ  one-hot result pulse, registered.
- `resp_data`  out  DATA_WIDTH  result, valid with `resp_valid`.
- `resp_err`  out  1  result is a timeout, valid with `resp_valid`.
- `alu_action`  out  ACTION_LEN  to ALU `action_in`.
- `alu_action_valid`  out  1  to ALU `action_valid`.
- `alu_operand_1`, `alu_operand_2`  out  DATA_WIDTH  to ALU operands.
- `alu_result`  in  DATA_WIDTH  from ALU `container_out`.
- `alu_result_valid`  in  1  from ALU `container_out_valid`.
- `op_count`  out  32  completed operations; wraps at 2^32.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` is set, grant the first set bit searching from `last_grant+1` modulo NUM_REQ.
  - Pulse `req_ready[grant]` in the same cycle.
  - Capture that requester's action and operands into the ALU registers, update `last_grant`, and go to ISSUE.
  - If no `req_valid` is set, stay in IDLE.
- ISSUE
  - Drive `alu_action_valid`=1 for exactly this cycle, with stable action and operands.
  - Go to WAIT.
- WAIT
  - On `alu_result_valid`, capture `alu_result` and go to RESP.
  - `alu_action_valid` stays 0.
- RESP
  - Registered outputs: `resp_valid[grant]`=1, `resp_data`=captured result, `resp_err`=0.
  - Increment `op_count`; return to IDLE.
- No response backpressure: a requester must accept `resp_valid` unconditionally. A requester may present a new `req_valid` while its previous request is outstanding; it is not granted before RESP completes.
- `req_valid` on a non-granted requester is held off and re-arbitrated in the next IDLE. Fairness: within every NUM_REQ grants, each continuously requesting requester is granted at least once.
- `alu_result_valid` outside WAIT is ignored.
- Reset
  - Zeroes every output and `op_count`, sets the state to IDLE and sets `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - A reset mid-operation drops the outstanding request with no response.
  - The ALU must be reset together with this block.

## Timing
- Cycle 0: IDLE with `req_ready` pulse. Cycle 1: ISSUE. Cycle 2: WAIT, ALU in OUTPUT. Cycle 3: WAIT, `alu_result_valid`=1. Cycle 4: RESP, `resp_valid`=1. Cycle 5: IDLE, earliest next accept.
- Request-to-response latency: 4 cycles. Peak throughput: one operation per 5 cycles.
- `req_ready` is 0 in every state except IDLE.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined
  - An 8-bit wait counter clears on ISSUE and increments each WAIT cycle.
  - If the counter reaches `TIMEOUT_CYCLES` without `alu_result_valid`, go to RESP with `resp_err`=1 and `resp_data`=0; `op_count` still increments.
  - If `alu_result_valid` arrives in the same cycle as the limit, it counts as a normal response.
- Not defined: WAIT waits indefinitely, `resp_err` is tied to 0, and no counter is synthesized.

## Structure
- Shared package `rmt_alu_pkg`:
  - state encoding localparams;
  - opcode field constants (`ALU_OP_MSB`=24, `ALU_OP_LSB`=21);
  - opcode values ADD=4'b0001, SUB=4'b0010, OR=4'b0101, GEQ=4'b0110, SET=4'b1110.
- One sub-module, `rr_arbiter`: parameterized NUM_REQ round-robin grant logic, with inputs request vector and last grant, and output one-hot grant.
- The ALU is instantiated by the parent, not by this block.

## Test plan
- Single ADD: requester 2 sends action[24:21]=0001, op1=5, op2=7 → `req_ready[2]` at cycle 0, `alu_action_valid` at cycle 1 only, `resp_valid[2]` at cycle 4, `resp_data`=12, `op_count`=1.
- Contention: all 4 requesters continuously send SUB 10−3 after reset → grant order 0,1,2,3,0; each receives 7; responses are 5 cycles apart.
- Back-to-back from one requester: requester 1 holds `req_valid` with GEQ 3≥9 and then 9≥3 → responses 0 and 1, with no other grants interleaved.
- Stray `alu_result_valid` pulsed in IDLE with no request → no `resp_valid`; `op_count` unchanged.
- Reset asserted in WAIT → all outputs 0 next cycle; no response for the dropped request; the next request from requester 3 is granted first.
- With `ALU_ARB_TIMEOUT_EN`: the ALU model withholds its response and `TIMEOUT_CYCLES`=15 → `resp_valid` with `resp_err`=1 and `resp_data`=0, 15 WAIT cycles after ISSUE.
